// File: rtl/rancnet_vote_classifier.sv
// rancnet_vote_classifier
//   Sink for the RANC grid output spike stream. Votes are accumulated per
//   class (class = spike id mod NUM_CLASSES) together with a per-id spike
//   bitmap. A frame_done pulse in IDLE snapshots and clears the live state,
//   a linear scan resolves the argmax class (ties go to the lowest index),
//   and the result is offered on a valid/ready port.
//   Live collection never stops: a frame_done seen while busy is dropped,
//   flagged in the sticky frame_overrun, and its spikes merge into the next
//   frame.
module rancnet_vote_classifier #(
  parameter int NUM_CLASSES  = 3,
  parameter int PACKET_WIDTH = 8,
  parameter int NUM_OUTPUTS  = 256,
  parameter int COUNT_WIDTH  = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PACKET_WIDTH-1:0]        packet_out,
  input  logic                           packet_out_valid,
  input  logic                           frame_done,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [$clog2(NUM_CLASSES)-1:0] result_class,
  output logic [COUNT_WIDTH-1:0]         result_votes,
  output logic                           result_saturated,
  output logic [NUM_OUTPUTS-1:0]         spike_bitmap,
  output logic                           frame_overrun,
  output logic                           busy
);

  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam logic [PACKET_WIDTH-1:0] NC_PKT   = PACKET_WIDTH'(NUM_CLASSES);
  localparam logic [CLS_W-1:0]        LAST_IDX = CLS_W'(NUM_CLASSES - 1);
  localparam logic [COUNT_WIDTH-1:0]  CNT_MAX  = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Saturating increment: the counter parks at its maximum value.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    logic [COUNT_WIDTH-1:0] r;
    if (v != CNT_MAX) begin
      r = v + COUNT_WIDTH'(1);
    end else begin
      r = CNT_MAX;
    end
    return r;
  endfunction

  state_t                   state_q, state_d;

  // live frame state
  logic [COUNT_WIDTH-1:0]   cnt_q [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0]   cnt_d [NUM_CLASSES];
  logic                     live_sat_q, live_sat_d;
  logic [NUM_OUTPUTS-1:0]   live_bitmap_q, live_bitmap_d;

  // snapshot of the completed frame
  logic [COUNT_WIDTH-1:0]   snap_cnt_q [NUM_CLASSES];
  logic [COUNT_WIDTH-1:0]   snap_cnt_d [NUM_CLASSES];
  logic                     snap_sat_q, snap_sat_d;
  logic [NUM_OUTPUTS-1:0]   snap_bitmap_q, snap_bitmap_d;

  // argmax scan
  logic [CLS_W-1:0]         idx_q, idx_d;
  logic [CLS_W-1:0]         best_q, best_d;
  logic [COUNT_WIDTH-1:0]   best_votes_q, best_votes_d;

  // result and status registers
  logic [CLS_W-1:0]         result_class_q, result_class_d;
  logic [COUNT_WIDTH-1:0]   result_votes_q, result_votes_d;
  logic                     result_sat_q, result_sat_d;
  logic                     result_valid_q, result_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  logic                     snap_take_s;
  logic [CLS_W-1:0]         pkt_cls_s;

  assign pkt_cls_s = CLS_W'(packet_out % NC_PKT);

  // FSM next state, scan datapath and result capture.
  always_comb begin
    state_d        = state_q;
    snap_take_s    = 1'b0;
    idx_d          = idx_q;
    best_d         = best_q;
    best_votes_d   = best_votes_q;
    result_class_d = result_class_q;
    result_votes_d = result_votes_q;
    result_sat_d   = result_sat_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_done) begin
          snap_take_s  = 1'b1;
          state_d      = ST_SCAN;
          idx_d        = '0;
          best_d       = '0;
          best_votes_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // strict compare keeps the lowest index on ties
        if (snap_cnt_q[idx_q] > best_votes_q) begin
          best_d       = idx_q;
          best_votes_d = snap_cnt_q[idx_q];
        end else begin
          best_d       = best_q;
          best_votes_d = best_votes_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d        = ST_RESULT;
          result_class_d = best_d;
          result_votes_d = best_votes_d;
          result_sat_d   = snap_sat_q;
        end else begin
          idx_d = idx_q + CLS_W'(1);
        end
      end
      ST_RESULT: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    result_valid_d = (state_d == ST_RESULT);
    busy_d         = (state_d != ST_IDLE);
  end

  // Live vote collection; a snapshot clears first so a same-cycle spike lands in the new frame.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (snap_take_s) begin
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c];
      end
    end
    if (snap_take_s) begin
      live_sat_d    = 1'b0;
      live_bitmap_d = '0;
    end else begin
      live_sat_d    = live_sat_q;
      live_bitmap_d = live_bitmap_q;
    end

    if (packet_out_valid) begin
      cnt_d[pkt_cls_s]          = sat_inc(cnt_d[pkt_cls_s]);
      live_bitmap_d[packet_out] = 1'b1;
      if (cnt_d[pkt_cls_s] == CNT_MAX) begin
        live_sat_d = 1'b1;
      end else begin
        live_sat_d = live_sat_d;
      end
    end else begin
      live_sat_d = live_sat_d;
    end
  end

  // Snapshot capture and the sticky overrun flag.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (snap_take_s) begin
        snap_cnt_d[c] = cnt_q[c];
      end else begin
        snap_cnt_d[c] = snap_cnt_q[c];
      end
    end
    if (snap_take_s) begin
      snap_sat_d    = live_sat_q;
      snap_bitmap_d = live_bitmap_q;
    end else begin
      snap_sat_d    = snap_sat_q;
      snap_bitmap_d = snap_bitmap_q;
    end
    overrun_d = overrun_q | (frame_done & (state_q != ST_IDLE));
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cnt_q[c]      <= '0;
        snap_cnt_q[c] <= '0;
      end
      live_sat_q     <= 1'b0;
      live_bitmap_q  <= '0;
      snap_sat_q     <= 1'b0;
      snap_bitmap_q  <= '0;
      idx_q          <= '0;
      best_q         <= '0;
      best_votes_q   <= '0;
      result_class_q <= '0;
      result_votes_q <= '0;
      result_sat_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cnt_q[c]      <= cnt_d[c];
        snap_cnt_q[c] <= snap_cnt_d[c];
      end
      live_sat_q     <= live_sat_d;
      live_bitmap_q  <= live_bitmap_d;
      snap_sat_q     <= snap_sat_d;
      snap_bitmap_q  <= snap_bitmap_d;
      idx_q          <= idx_d;
      best_q         <= best_d;
      best_votes_q   <= best_votes_d;
      result_class_q <= result_class_d;
      result_votes_q <= result_votes_d;
      result_sat_q   <= result_sat_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign result_valid     = result_valid_q;
  assign result_class     = result_class_q;
  assign result_votes     = result_votes_q;
  assign result_saturated = result_sat_q;
  assign spike_bitmap     = snap_bitmap_q;
  assign frame_overrun    = overrun_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_rancnet_vote_classifier.sv
// Bench for rancnet_vote_classifier: directed vector table, hand-written
// corner sequences, and random traffic checked every cycle against a
// queue-based reference model of frames, votes and result timing.
module tb_rancnet_vote_classifier;

  localparam int NC      = 3;
  localparam int PW      = 8;
  localparam int NO      = 256;
  localparam int CW      = 9;
  localparam int SAT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] packet_out;
  logic          packet_out_valid;
  logic          frame_done;
  logic          result_valid;
  logic          result_ready;
  logic [1:0]    result_class;
  logic [CW-1:0] result_votes;
  logic          result_saturated;
  logic [NO-1:0] spike_bitmap;
  logic          frame_overrun;
  logic          busy;

  rancnet_vote_classifier #(
    .NUM_CLASSES(NC), .PACKET_WIDTH(PW), .NUM_OUTPUTS(NO), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .frame_done(frame_done),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_votes(result_votes),
    .result_saturated(result_saturated), .spike_bitmap(spike_bitmap),
    .frame_overrun(frame_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int            live_ids[$];
  int            snap_ids[$];
  int            m_phase;     // 0 idle, 1 resolving, 2 result offered
  int            m_cnt;
  bit            m_over;
  logic [1:0]    e_class;
  logic [CW-1:0] e_votes;
  bit            e_sat;
  logic [NO-1:0] e_bitmap;

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][7:0] ids;    // first id in ids[7]
    logic [1:0]      cls;
    logic [8:0]      votes;
    logic [15:0]     bm;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [NO-1:0] act, input logic [NO-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    live_ids.delete();
    snap_ids.delete();
    m_phase  = 0;
    m_cnt    = 0;
    m_over   = 1'b0;
    e_class  = '0;
    e_votes  = '0;
    e_sat    = 1'b0;
    e_bitmap = '0;
  endtask

  // Count votes of the snapshot frame and pick the lowest-index maximum.
  task automatic model_resolve();
    int votes [NC];
    int bv;
    int bc;
    for (int c = 0; c < NC; c++) votes[c] = 0;
    foreach (snap_ids[i]) votes[snap_ids[i] % NC]++;
    e_sat = 1'b0;
    bv = 0;
    bc = 0;
    for (int c = 0; c < NC; c++) begin
      if (votes[c] >= SAT_MAX) begin
        e_sat = 1'b1;
        votes[c] = SAT_MAX;
      end
      if (votes[c] > bv) begin
        bv = votes[c];
        bc = c;
      end
    end
    e_class = 2'(bc);
    e_votes = CW'(bv);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          if (frame_done) begin
            snap_ids = live_ids;
            live_ids.delete();
            e_bitmap = '0;
            foreach (snap_ids[i]) e_bitmap[snap_ids[i]] = 1'b1;
            m_phase = 1;
            m_cnt   = NC;
          end
        end
        1: begin
          if (frame_done) m_over = 1'b1;
          m_cnt--;
          if (m_cnt == 0) begin
            model_resolve();
            m_phase = 2;
          end
        end
        default: begin
          if (frame_done) m_over = 1'b1;
          if (result_ready) m_phase = 0;
        end
      endcase
      if (packet_out_valid) live_ids.push_back(int'(packet_out));
    end
  endtask

  task automatic compare_all();
    check("valid",     NO'(result_valid),     NO'(m_phase == 2));
    check("busy",      NO'(busy),             NO'(m_phase != 0));
    check("overrun",   NO'(frame_overrun),    NO'(m_over));
    check("class",     NO'(result_class),     NO'(e_class));
    check("votes",     NO'(result_votes),     NO'(e_votes));
    check("saturated", NO'(result_saturated), NO'(e_sat));
    check("bitmap",    spike_bitmap,          e_bitmap);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input int id);
    packet_out       = PW'(id);
    packet_out_valid = 1'b1;
    step();
    packet_out_valid = 1'b0;
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    step();
    frame_done       = 1'b0;
    packet_out_valid = 1'b0;
  endtask

  // Called right after the frame_done edge; result must appear NC edges later.
  task automatic wait_result(input string nm);
    int lat = 0;
    while (result_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({nm, "_latency"}, NO'(lat), NO'(NC));
  endtask

  task automatic accept();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("accept_drop", NO'(result_valid), NO'(0));
  endtask

  initial begin
    // {count, ids (first in MSB), class, votes, bitmap[15:0]}
    vecs[0] = '{n: 4'd5, ids: {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0}, cls: 2'd0, votes: 9'd2, bm: 16'h001F};
    vecs[1] = '{n: 4'd4, ids: {8'd5, 8'd8, 8'd11, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0}, cls: 2'd2, votes: 9'd3, bm: 16'h09A0};
    vecs[2] = '{n: 4'd0, ids: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, cls: 2'd0, votes: 9'd0, bm: 16'h0000};
    vecs[3] = '{n: 4'd4, ids: {8'd9, 8'd4, 8'd7, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0}, cls: 2'd1, votes: 9'd3, bm: 16'h0690};
    vecs[4] = '{n: 4'd5, ids: {8'd6, 8'd3, 8'd1, 8'd2, 8'd5, 8'd0, 8'd0, 8'd0}, cls: 2'd0, votes: 9'd2, bm: 16'h006E};

    rst = 1'b1;
    packet_out = '0;
    packet_out_valid = 1'b0;
    frame_done = 1'b0;
    result_ready = 1'b0;
    model_reset();
    #2;
    compare_all();
    step();
    step();
    rst = 1'b0;
    step();

    // directed vector table
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < int'(vecs[v].n); k++) send(int'(vecs[v].ids[7-k]));
      pulse_fd();
      wait_result($sformatf("vec%0d", v));
      check($sformatf("vec%0d_class", v), NO'(result_class), NO'(vecs[v].cls));
      check($sformatf("vec%0d_votes", v), NO'(result_votes), NO'(vecs[v].votes));
      check($sformatf("vec%0d_bitmap", v), spike_bitmap, NO'(vecs[v].bm));
      check($sformatf("vec%0d_sat", v), NO'(result_saturated), NO'(0));
      accept();
    end

    // spike in the same cycle as frame_done belongs to the new frame
    send(2);
    send(2);
    packet_out = PW'(1);
    packet_out_valid = 1'b1;
    pulse_fd();
    wait_result("same_cyc1");
    check("same_cyc1_class", NO'(result_class), NO'(2));
    check("same_cyc1_votes", NO'(result_votes), NO'(2));
    accept();
    pulse_fd();
    wait_result("same_cyc2");
    check("same_cyc2_class", NO'(result_class), NO'(1));
    check("same_cyc2_votes", NO'(result_votes), NO'(1));
    check("same_cyc2_bitmap", spike_bitmap, NO'(2));
    accept();

    // frame_done while a result is pending is dropped and flagged
    send(0);
    send(0);
    pulse_fd();
    wait_result("ovr1");
    send(1);
    packet_out = PW'(4);
    packet_out_valid = 1'b1;
    pulse_fd();
    check("ovr_flag", NO'(frame_overrun), NO'(1));
    check("ovr_hold_class", NO'(result_class), NO'(0));
    check("ovr_hold_votes", NO'(result_votes), NO'(2));
    check("ovr_hold_valid", NO'(result_valid), NO'(1));
    accept();
    pulse_fd();
    wait_result("ovr2");
    check("ovr2_class", NO'(result_class), NO'(1));
    check("ovr2_votes", NO'(result_votes), NO'(2));
    accept();

    // counter saturation
    for (int k = 0; k < 600; k++) send(0);
    pulse_fd();
    wait_result("sat");
    check("sat_votes", NO'(result_votes), NO'(511));
    check("sat_flag", NO'(result_saturated), NO'(1));
    accept();

    // reset while scanning aborts with everything cleared
    send(3);
    send(5);
    pulse_fd();
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_busy", NO'(busy), NO'(0));
    check("rst_votes", NO'(result_votes), NO'(0));
    check("rst_bitmap", spike_bitmap, NO'(0));
    step();
    rst = 1'b0;
    step();

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      packet_out_valid = (($urandom % 3) != 0);
      packet_out       = (($urandom % 2) != 0) ? PW'($urandom_range(0, 11)) : PW'($urandom);
      frame_done       = (($urandom % 16) == 0);
      result_ready     = (($urandom % 3) != 0);
      rst              = (i == 750);
      step();
    end
    rst = 1'b0;
    packet_out_valid = 1'b0;
    frame_done = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
